uart_rx: RTL



---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_sampler.sv | 58 +++++
 rtl/uart_rx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal oversampling
// ratios and the parity helper used by both the RX and TX sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // Parity bit that accompanies `data`: even parity when par_type is 0,
  // odd parity when par_type is 1. Unused upper bits must be zero.
  function automatic logic uart_parity(input logic [31:0] data, input logic par_type);
    return (^data) ^ par_type;
  endfunction

  // Any oversampling ratio other than 16 or 32 falls back to 8.
  function automatic logic [31:0] uart_prescale_legal(input logic [31:0] prescale);
    case (prescale)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-time counter and three-point majority sampler. edge_cnt sits at 0
// while run is low, so the cycle that first sees the start bit counts as
// position 0 of the start bit.
module uart_rx_sampler #(
  parameter int prescaleWidth = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [prescaleWidth-1:0] prescale,
  input  logic                     rx_s,
  output logic                     sampled_bit,
  output logic                     sample_done,
  output logic                     bit_end
);

  logic [prescaleWidth-1:0] edge_cnt;
  logic [prescaleWidth-1:0] half;
  logic [prescaleWidth-1:0] mid_lo;
  logic [prescaleWidth-1:0] mid_hi;
  logic [prescaleWidth-1:0] decide;
  logic [prescaleWidth-1:0] last;
  logic [2:0]               samples;

  assign half   = prescale >> 1;
  assign mid_lo = half - prescaleWidth'(1);
  assign mid_hi = half + prescaleWidth'(1);
  assign decide = half + prescaleWidth'(2);
  assign last   = prescale - prescaleWidth'(1);

  // Advance the in-bit position and capture the line around mid-bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_cnt <= '0;
      samples  <= 3'b111;
    end else begin
      if (!run) begin
        edge_cnt <= '0;
      end else if (edge_cnt == last) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + prescaleWidth'(1);
      end
      if (run) begin
        if (edge_cnt == mid_lo) samples[0] <= rx_s;
        if (edge_cnt == half)   samples[1] <= rx_s;
        if (edge_cnt == mid_hi) samples[2] <= rx_s;
      end
    end
  end

  assign sampled_bit = (samples[0] & samples[1]) |
                       (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);
  assign sample_done = (edge_cnt == decide);
  assign bit_end     = (edge_cnt == last);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: synchroniser, frame FSM, deserialiser and
// parity/stop checking. Results are single-cycle registered pulses.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle, waiting for rx_s low
// START  | start bit; a majority of 1 at mid-bit is a glitch
// DATA   | shifting data bits in, LSB first
// PARITY | parity bit, compared against the received data
// STOP   | stop bit; result issued at mid-bit, then straight back to IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int dataWidth     = 8,
  parameter int prescaleWidth = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_in,
  input  logic [prescaleWidth-1:0] prescale,
  input  logic                     par_en,
  input  logic                     par_type,
  output logic [dataWidth-1:0]     p_data,
  output logic                     data_valid,
  output logic                     par_err,
  output logic                     stop_err
);

  localparam int CW = (dataWidth > 1) ? $clog2(dataWidth) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(dataWidth - 1);

  uart_state_e              state;
  logic [1:0]               sync;
  logic                     rx_s;
  logic [CW-1:0]            bit_cnt;
  logic [dataWidth-1:0]     shift_reg;
  logic [prescaleWidth-1:0] p_lat;
  logic                     pe_lat;
  logic                     pt_lat;
  logic                     par_bad;
  logic                     cnt_run;
  logic                     sampled_bit;
  logic                     sample_done;
  logic                     bit_end;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx_in};
    end
  end

  assign rx_s = sync[1];

  // The bit counter runs from the first low cycle in IDLE and is cleared
  // in the same cycle the FSM drops back to IDLE, so a new start bit can
  // be timed from position 0 on the very next cycle.
  always_comb begin
    cnt_run = 1'b1;
    case (state)
      IDLE:    cnt_run = ~rx_s;
      START:   if (sample_done && sampled_bit) cnt_run = 1'b0;
      STOP:    if (sample_done) cnt_run = 1'b0;
      default: cnt_run = 1'b1;
    endcase
  end

  uart_rx_sampler #(
    .prescaleWidth(prescaleWidth)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .run        (cnt_run),
    .prescale   (p_lat),
    .rx_s       (rx_s),
    .sampled_bit(sampled_bit),
    .sample_done(sample_done),
    .bit_end    (bit_end)
  );

  // Frame FSM with deserialiser, checkers and registered result pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      p_lat      <= prescaleWidth'(PRESCALE_8);
      pe_lat     <= 1'b0;
      pt_lat     <= 1'b0;
      par_bad    <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            p_lat   <= prescaleWidth'(uart_prescale_legal(32'(prescale)));
            pe_lat  <= par_en;
            pt_lat  <= par_type;
            bit_cnt <= '0;
            par_bad <= 1'b0;
          end
        end
        START: begin
          if (sample_done && sampled_bit) begin
            state <= IDLE;
          end else if (bit_end) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (sample_done) begin
            shift_reg <= {sampled_bit, shift_reg[dataWidth-1:1]};
          end
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= pe_lat ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        PARITY: begin
          if (sample_done) begin
            par_bad <= (sampled_bit != uart_parity(32'(shift_reg), pt_lat));
          end
          if (bit_end) begin
            state <= STOP;
          end
        end
        STOP: begin
          if (sample_done) begin
            state <= IDLE;
            if (!sampled_bit) begin
              stop_err <= 1'b1;
            end else if (par_bad) begin
              par_err <= 1'b1;
            end else begin
              p_data     <= shift_reg;
              data_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
